// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the MEM stage, the memory access controller and the SRAM pads.
// The slave view belongs to the controller. The master view belongs to the pipeline and board side.
interface mem_access_ctrl_if #(
    parameter int SRAM_AW = 18
);
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport slave (
        input  rd_en, wr_en, addr, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

    modport master (
        output rd_en, wr_en, addr, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Splits each 32-bit MEM-stage access into two half-word phases on a 16-bit asynchronous SRAM.
// While an access is in flight, ready stays low so that the pipeline freezes.
module mem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus
);
    localparam int         WIDX_W   = SRAM_AW - 1;
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic         op_wr, op_nxt;
    logic [31:0]  addr_q, addr_nxt;
    logic [31:0]  wdata_q, wdata_nxt;
    logic [31:0]  rdata_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic [15:0]  dq_out_q;
    logic         dq_oe_q, we_n_q, oe_n_q;
    logic         ready;
    logic         phase_nxt;
    logic [WIDX_W-1:0] widx_nxt;

    // NOTE: every output of always_comb gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_wr;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready   = ~(bus.rd_en | bus.wr_en);
                cnt_nxt = 4'd0;
                if (bus.rd_en | bus.wr_en) begin
                    state_nxt = LO;
                    op_nxt    = bus.wr_en;
                    addr_nxt  = bus.addr;
                    wdata_nxt = bus.wdata;
                end
            end
            LO: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = HI;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HI: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                // Requests seen here still belong to the instruction that is completing.
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign phase_nxt = (state_nxt == LO) || (state_nxt == HI);
    assign widx_nxt  = WIDX_W'((addr_nxt - BASE_ADDR) >> 2);

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            op_wr   <= op_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
        end
    end

    // Pad controls are registered from the next state so that strobes change only on clock edges.
    // The asynchronous reset still releases them at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            rdata_q     <= '0;
        end else begin
            if (phase_nxt) begin
                sram_addr_q <= {widx_nxt, (state_nxt == HI)};
                dq_oe_q     <= op_nxt;
                we_n_q      <= ~op_nxt;
                oe_n_q      <= op_nxt;
                if (op_nxt)
                    dq_out_q <= (state_nxt == HI) ? wdata_nxt[31:16] : wdata_nxt[15:0];
            end else begin
                dq_oe_q <= 1'b0;
                we_n_q  <= 1'b1;
                oe_n_q  <= 1'b1;
            end
            if (!op_wr && cnt == CNT_LAST) begin
                if (state == LO) rdata_q[15:0]  <= bus.sram_dq_in;
                if (state == HI) rdata_q[31:16] <= bus.sram_dq_in;
            end
        end
    end

    assign bus.ready       = ready;
    assign bus.rdata       = rdata_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_oe_n   = oe_n_q;
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences 32-bit data-memory accesses from the MEM stage onto an external 16-bit asynchronous SRAM. Each word access takes two half-word bus phases. While an access is in flight, the block drops ready, and the hazard/freeze logic uses ready to freeze the IF..MEM pipeline registers. It sits between the MEM stage (addr = ALU result, wdata = store value) and the board SRAM pins. Read data feeds the MEM->WB register.

Parameters:
BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.
SRAM_AW, 18, SRAM half-word address width.
WAIT_CYCLES, 2, cycles each half-word phase holds the bus; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
rd_en  in  1  MEM-stage load request, level; held until ready.
wr_en  in  1  MEM-stage store request, level; held until ready.
addr  in  32  CPU byte address, word aligned.
wdata  in  32  store data.
rdata  out  32  load data.
ready  out  1  high = no access pending or access completing this cycle; pipeline freeze = ~ready.
sram_addr  out  SRAM_AW  half-word address.
sram_dq_out  out  16  write data to the pad.
sram_dq_oe  out  1  pad output enable for the DQ bus.
sram_dq_in  in  16  read data from the pad.
sram_we_n  out  1  SRAM write strobe, active-low.
sram_oe_n  out  1  SRAM output enable, active-low.

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-low.
- States: IDLE, LO, HI, DONE. A 4-bit phase counter cnt runs in LO and HI.
- Reset (rst=0): immediate, asynchronous.
  - State goes to IDLE, cnt=0, latched addr/wdata=0, rdata=0.
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
  - Reset mid-access aborts the access; the strobe deasserts without waiting for a clock edge.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational, so the pipeline freezes in the request cycle itself.
  - On rd_en|wr_en: latch addr, wdata, and op (write if wr_en, else read), then go to LO with cnt=0.
  - If rd_en and wr_en are both high, the access is a write; rdata is not updated.
- Word index: widx = (addr - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - LO phase uses sram_addr = {widx, 1'b0}; HI phase uses {widx, 1'b1}.
  - Addresses below BASE_ADDR wrap modulo 2^(SRAM_AW-1). There is no error flag.
- LO and HI phases each last WAIT_CYCLES cycles. On cnt == WAIT_CYCLES-1: LO goes to HI with cnt reset to 0, HI goes to DONE.
- Write phases:
  - sram_dq_oe=1, sram_we_n=0, sram_oe_n=1.
  - sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
- Read phases:
  - sram_dq_oe=0, sram_we_n=1, sram_oe_n=0.
  - rdata[15:0] captures sram_dq_in on the last LO cycle; rdata[31:16] captures it on the last HI cycle.
- Outside active phases: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0. sram_addr holds its last value.
- DONE:
  - ready=1 for exactly one cycle; the pipeline advances on this edge.
  - Request inputs are ignored in DONE because they still belong to the completing instruction. Next state is IDLE.
- Latency: request accepted in cycle T0. ready is low for T0..T(2*WAIT_CYCLES) and high in T(2*WAIT_CYCLES+1).
  - Stall length = 2*WAIT_CYCLES+1 cycles.
  - Back-to-back accesses have one IDLE cycle between them.
- rdata holds its value until the next completed read. Writes never change rdata.
- ready is driven from state and the request inputs only; it has no dependence on sram_dq_in.

Test Plan:
- Reset: hold rst=0 with random inputs -> ready=1 (inputs low), sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, rdata=0.
- Write, WAIT_CYCLES=2: wr_en, addr=1032, wdata=0xDEADBEEF -> ready low 5 cycles; sram_addr=4 with dq 0xBEEF and we_n=0 for 2 cycles; then sram_addr=5 with dq 0xDEAD for 2 cycles; then ready=1 for 1 cycle.
- Read back with an SRAM model: rd_en, addr=1032 -> in the DONE cycle rdata=0xDEADBEEF, sram_oe_n=0 during both phases, dq_oe=0 throughout.
- Both enables high at addr=1024 with wdata=0x12345678 -> write to SRAM halves 0/1 occurs, rdata unchanged.
- Reset asserted in 2nd cycle of the HI phase of a write -> sram_we_n=1 immediately; after release, IDLE and ready=1.
- Back-to-back store then load with WAIT_CYCLES=1 -> stalls of 3 cycles each, separated by one IDLE cycle; load returns the stored word.
